// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch front end of the 16-bit processor. It holds the PC, drives
// the byte address into the 128x16 instruction RAM, captures the returned word,
// and buffers up to two fetched instructions for the decode stage behind a
// valid/ready handshake. Branch redirects flush the buffer. An all-zero word,
// which pads unused instruction memory, stops fetching.
//
// Ports:
//   CLK          in   1   system clock, all state on the rising edge
//   RESET        in   1   asynchronous, active-high reset
//   ADDR         out  8   byte address to instruction RAM (equals PC, bit 0 = 0)
//   Q            in  16   instruction word from RAM, combinational in ADDR
//   INSTR        out 16   head-of-queue instruction
//   INSTR_PC     out  8   byte address INSTR was fetched from
//   INSTR_VALID  out  1   head entry is valid
//   INSTR_READY  in   1   decode accepts the head this cycle
//   FLUSH        in   1   branch/jump redirect, one-cycle pulse
//   FLUSH_ADDR   in   8   redirect target byte address (bit 0 forced to 0)
//   HALTED       out  1   an all-zero word was fetched, fetching stopped
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter int          BOOT_WAIT = 1,
    parameter int          DEPTH     = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [7:0]  ADDR,
    input  logic [15:0] Q,
    output logic [15:0] INSTR,
    output logic [7:0]  INSTR_PC,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY,
    input  logic        FLUSH,
    input  logic [7:0]  FLUSH_ADDR,
    output logic        HALTED
);

    localparam logic [3:0] LP_BOOT  = 4'(BOOT_WAIT);
    localparam logic [1:0] LP_DEPTH = 2'(DEPTH);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_boot_cnt;
    logic [7:0]  r_pc;
    logic [1:0]  r_count;
    logic [15:0] r_instr;      // queue head, drives INSTR directly
    logic [7:0]  r_instr_pc;
    logic [15:0] r_q1_instr;   // second queue entry
    logic [7:0]  r_q1_pc;
    logic        r_halted;

    logic w_pop;
    logic w_fetch_en;
    logic w_fetch;
    logic w_zero;
    logic w_push;
    logic w_halt_hit;

    assign w_pop      = (r_count != 2'd0) & INSTR_READY;
    // The edge that ends the boot wait already performs the first fetch, so
    // the first INSTR_VALID appears BOOT_WAIT + 1 edges after reset release.
    assign w_fetch_en = (r_state == S_RUN) | ((r_state == S_BOOT) & (r_boot_cnt == 4'd0));
    assign w_fetch    = ~FLUSH & w_fetch_en & ((r_count < LP_DEPTH) | w_pop);
    assign w_zero     = (Q == 16'h0000);
    assign w_push     = w_fetch & ~w_zero;
    assign w_halt_hit = w_fetch & w_zero;

    assign ADDR        = r_pc;
    assign INSTR       = r_instr;
    assign INSTR_PC    = r_instr_pc;
    assign INSTR_VALID = (r_count != 2'd0);
    assign HALTED      = r_halted;

    // Fetch control FSM, PC, and the two-entry instruction queue.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_BOOT;
            r_boot_cnt <= LP_BOOT;
            r_pc       <= RESET_PC & 8'hFE;
            r_count    <= 2'd0;
            r_instr    <= 16'h0000;
            r_instr_pc <= 8'h00;
            r_q1_instr <= 16'h0000;
            r_q1_pc    <= 8'h00;
            r_halted   <= 1'b0;
        end else if (FLUSH) begin
            // Redirect wins over any pop or fetch in the same cycle.
            r_state    <= S_RUN;
            r_boot_cnt <= 4'd0;
            r_pc       <= FLUSH_ADDR & 8'hFE;
            r_count    <= 2'd0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    if (r_boot_cnt != 4'd0) begin
                        r_boot_cnt <= r_boot_cnt - 4'd1;
                    end else if (w_halt_hit) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_halt_hit) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase

            // A halting word is never enqueued and leaves the PC on itself.
            if (w_push) begin
                r_pc <= r_pc + 8'd2;
            end else begin
                r_pc <= r_pc;
            end

            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_instr    <= Q;
                        r_instr_pc <= r_pc;
                    end else begin
                        r_q1_instr <= Q;
                        r_q1_pc    <= r_pc;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_instr    <= r_q1_instr;
                        r_instr_pc <= r_q1_pc;
                    end else begin
                        r_instr    <= r_instr;
                        r_instr_pc <= r_instr_pc;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; a full queue shifts to keep order.
                    if (r_count == 2'd1) begin
                        r_instr    <= Q;
                        r_instr_pc <= r_pc;
                    end else begin
                        r_instr    <= r_q1_instr;
                        r_instr_pc <= r_q1_pc;
                        r_q1_instr <= Q;
                        r_q1_pc    <= r_pc;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  addr_m, addr_w;
    logic [15:0] q_m, q_w;
    logic [15:0] instr_m, instr_w;
    logic [7:0]  ipc_m, ipc_w;
    logic        valid_m, valid_w;
    logic        ready_m, ready_w;
    logic        flush_m, flush_w;
    logic [7:0]  faddr_m, faddr_w;
    logic        halted_m, halted_w;

    logic [15:0] mem [0:127];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    assign q_m = mem[7'(addr_m >> 1)];
    assign q_w = mem[7'(addr_w >> 1)];

    instr_fetch_unit #(.RESET_PC(8'h00), .BOOT_WAIT(1), .DEPTH(2)) u_dut (
        .CLK(CLK), .RESET(RESET), .ADDR(addr_m), .Q(q_m), .INSTR(instr_m),
        .INSTR_PC(ipc_m), .INSTR_VALID(valid_m), .INSTR_READY(ready_m),
        .FLUSH(flush_m), .FLUSH_ADDR(faddr_m), .HALTED(halted_m)
    );

    instr_fetch_unit #(.RESET_PC(8'hFE), .BOOT_WAIT(0), .DEPTH(2)) u_dut_wrap (
        .CLK(CLK), .RESET(RESET), .ADDR(addr_w), .Q(q_w), .INSTR(instr_w),
        .INSTR_PC(ipc_w), .INSTR_VALID(valid_w), .INSTR_READY(ready_w),
        .FLUSH(flush_w), .FLUSH_ADDR(faddr_w), .HALTED(halted_w)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [7:0]  pc;
        logic [15:0] w;
    } ent_t;

    ent_t       m_q[$];
    logic [7:0] m_pc;
    int         m_wait;
    bit         m_halt;

    task automatic m_reset();
        m_q.delete();
        m_pc   = 8'h00;
        m_wait = 1;
        m_halt = 1'b0;
    endtask

    task automatic m_step(input bit rdy, input bit fl, input logic [7:0] fa);
        bit   pop;
        bit   can;
        bit   fetch;
        ent_t e;
        pop = rdy && (m_q.size() > 0);
        if (fl) begin
            m_q.delete();
            m_pc   = fa & 8'hFE;
            m_halt = 1'b0;
            m_wait = 0;
        end else begin
            if (m_wait > 0) begin
                m_wait--;
                can = 1'b0;
            end else begin
                can = !m_halt;
            end
            fetch = can && ((m_q.size() < 2) || pop);
            if (pop) void'(m_q.pop_front());
            if (fetch) begin
                if (mem[m_pc[7:1]] == 16'h0000) begin
                    m_halt = 1'b1;
                end else begin
                    e.pc = m_pc;
                    e.w  = mem[m_pc[7:1]];
                    m_q.push_back(e);
                    m_pc = m_pc + 8'd2;
                end
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rdy;
        logic        fl;
        logic [7:0]  fa;
        logic        ev;
        logic [15:0] ei;
        logic [7:0]  ep;
        logic [7:0]  ea;
        logic        eh;
    } vec_t;

    vec_t tbl [25];

    initial begin
        RESET   = 1'b1;
        ready_m = 1'b0;
        flush_m = 1'b0;
        faddr_m = 8'h00;
        ready_w = 1'b1;
        flush_w = 1'b0;
        faddr_w = 8'h00;
        for (int i = 0; i < 128; i++) mem[i] = 16'hA000 | 16'(i);
        mem[0]  = 16'hF001;
        mem[1]  = 16'hF491;
        mem[2]  = 16'hFFF9;
        mem[28] = 16'h0000;

        //             rdy   fl    fa     ev    ei        ep     ea     eh
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'hF001, 8'h00, 8'h02, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'hF491, 8'h02, 8'h04, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'hFFF9, 8'h04, 8'h06, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hF001, 8'h00, 8'h02, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hF001, 8'h00, 8'h04, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hF001, 8'h00, 8'h04, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hF001, 8'h00, 8'h04, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hF001, 8'h00, 8'h04, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'hF491, 8'h02, 8'h06, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'hFFF9, 8'h04, 8'h08, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'hA003, 8'h06, 8'h0A, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hA003, 8'h06, 8'h0A, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 8'h11, 1'b0, 16'h0000, 8'h00, 8'h10, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'hA008, 8'h10, 8'h12, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 8'h34, 1'b0, 16'h0000, 8'h00, 8'h34, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hA01A, 8'h34, 8'h36, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hA01A, 8'h34, 8'h38, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hA01A, 8'h34, 8'h38, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'hA01B, 8'h36, 8'h38, 1'b1};
        tbl[21] = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h38, 1'b1};
        tbl[22] = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h38, 1'b1};
        tbl[23] = '{1'b1, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0};
        tbl[24] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'hF001, 8'h00, 8'h02, 1'b0};

        // Reset state while RESET is held.
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_valid",  32'(valid_m),  32'd0);
        chk("rst_instr",  32'(instr_m),  32'd0);
        chk("rst_ipc",    32'(ipc_m),    32'd0);
        chk("rst_halted", 32'(halted_m), 32'd0);
        chk("rst_addr",   32'(addr_m),   32'd0);
        chk("rst_addr_wrap", 32'(addr_w), 32'hFE);
        RESET = 1'b0;

        // Directed table: boot latency, stall, flush, halt and resume.
        for (int k = 0; k < 25; k++) begin
            ready_m = tbl[k].rdy;
            flush_m = tbl[k].fl;
            faddr_m = tbl[k].fa;
            @(posedge CLK);
            #1;
            flush_m = 1'b0;
            chk($sformatf("tbl%0d_valid", k), 32'(valid_m), 32'(tbl[k].ev));
            chk($sformatf("tbl%0d_addr", k), 32'(addr_m), 32'(tbl[k].ea));
            chk($sformatf("tbl%0d_halted", k), 32'(halted_m), 32'(tbl[k].eh));
            if (tbl[k].ev) begin
                chk($sformatf("tbl%0d_instr", k), 32'(instr_m), 32'(tbl[k].ei));
                chk($sformatf("tbl%0d_ipc", k), 32'(ipc_m), 32'(tbl[k].ep));
            end
        end

        // Fill the queue, then assert RESET between clock edges.
        ready_m = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("full_valid", 32'(valid_m), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_valid",  32'(valid_m),  32'd0);
        chk("async_instr",  32'(instr_m),  32'd0);
        chk("async_ipc",    32'(ipc_m),    32'd0);
        chk("async_addr",   32'(addr_m),   32'd0);
        chk("async_halted", 32'(halted_m), 32'd0);
        @(posedge CLK);
        #1;
        RESET   = 1'b0;
        ready_m = 1'b1;
        @(posedge CLK);
        #1;
        chk("reboot_e1_valid", 32'(valid_m), 32'd0);
        chk("wrap_e1_valid",   32'(valid_w), 32'd1);
        chk("wrap_e1_ipc",     32'(ipc_w),   32'hFE);
        chk("wrap_e1_instr",   32'(instr_w), 32'hA07F);
        @(posedge CLK);
        #1;
        chk("reboot_e2_valid", 32'(valid_m), 32'd1);
        chk("reboot_e2_instr", 32'(instr_m), 32'hF001);
        chk("reboot_e2_ipc",   32'(ipc_m),   32'h00);
        chk("wrap_e2_ipc",     32'(ipc_w),   32'h00);
        chk("wrap_e2_instr",   32'(instr_w), 32'hF001);

        // Randomized run against the reference model.
        RESET = 1'b1;
        for (int i = 0; i < 128; i++) begin
            if ($urandom_range(0, 11) == 0) mem[i] = 16'h0000;
            else mem[i] = 16'($urandom) | 16'h0001;
        end
        #10;
        RESET = 1'b0;
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            ready_m = ($urandom_range(0, 9) < 7);
            flush_m = ($urandom_range(0, 19) == 0);
            faddr_m = 8'($urandom_range(0, 255));
            @(posedge CLK);
            m_step(ready_m, flush_m, faddr_m);
            #1;
            chk("rnd_valid",  32'(valid_m),  32'(m_q.size() > 0));
            chk("rnd_addr",   32'(addr_m),   32'(m_pc));
            chk("rnd_halted", 32'(halted_m), 32'(m_halt));
            if (m_q.size() > 0) begin
                chk("rnd_instr", 32'(instr_m), 32'(m_q[0].w));
                chk("rnd_ipc",   32'(ipc_m),   32'(m_q[0].pc));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
